// File: rtl/roi_window_overlay.sv
// roi_window_overlay: multi-window ROI classifier and overlay for a pixel stream.
// Ports: pixelclk/reset; i_rgb, i_hsync, i_vsync, i_de, hcount, vcount (pixel in);
//        win_h_l/h_r/v_l/v_r, win_en, win_mode, cfg_update (live config, committed at frame edge);
//        cfg_busy; o_rgb, o_hsync, o_vsync, o_de, o_hit (2-cycle latency);
//        frame_done, win_count (per-window pixel counts of the last complete frame).
module roi_window_overlay #(
    parameter int          DW        = 24,
    parameter int          CW        = 12,
    parameter int          NUM_WIN   = 4,
    parameter logic [DW-1:0] FILL_RGB  = 24'h000000,
    parameter logic [DW-1:0] BLANK_RGB = 24'hffffff,
    parameter logic [DW-1:0] MARK_RGB  = 24'hff0000,
    parameter bit          VS_POL    = 1'b1
) (
    input  logic                    pixelclk,
    input  logic                    reset,
    input  logic [DW-1:0]           i_rgb,
    input  logic                    i_hsync,
    input  logic                    i_vsync,
    input  logic                    i_de,
    input  logic [CW-1:0]           hcount,
    input  logic [CW-1:0]           vcount,
    input  logic [NUM_WIN*CW-1:0]   win_h_l,
    input  logic [NUM_WIN*CW-1:0]   win_h_r,
    input  logic [NUM_WIN*CW-1:0]   win_v_l,
    input  logic [NUM_WIN*CW-1:0]   win_v_r,
    input  logic [NUM_WIN-1:0]      win_en,
    input  logic [2*NUM_WIN-1:0]    win_mode,
    input  logic                    cfg_update,
    output logic                    cfg_busy,
    output logic [DW-1:0]           o_rgb,
    output logic                    o_hsync,
    output logic                    o_vsync,
    output logic                    o_de,
    output logic [NUM_WIN-1:0]      o_hit,
    output logic                    frame_done,
    output logic [NUM_WIN*24-1:0]   win_count
);

    localparam logic [CW-1:0] ONE     = 1;
    localparam logic [23:0]   ACC_MAX = 24'hFFFFFF;

    // frame boundary / commit control
    logic vs_prev_q, vs_prev_d;
    logic pending_q, pending_d;
    logic primed_q, primed_d;
    logic boundary, commit;

    // shadow configuration
    logic [NUM_WIN-1:0]    en_s_q, en_s_d;
    logic [NUM_WIN*CW-1:0] hl_s_q, hl_s_d;
    logic [NUM_WIN*CW-1:0] hr_s_q, hr_s_d;
    logic [NUM_WIN*CW-1:0] vl_s_q, vl_s_d;
    logic [NUM_WIN*CW-1:0] vr_s_q, vr_s_d;
    logic [2*NUM_WIN-1:0]  mode_s_q, mode_s_d;

    // stage-0 window evaluation
    logic [NUM_WIN-1:0] hit;
    logic               sel_any;
    logic [1:0]         sel_mode;
    logic               sel_ring;

    // stage 1
    logic [DW-1:0]      rgb1_q, rgb1_d;
    logic               hs1_q, hs1_d;
    logic               vs1_q, vs1_d;
    logic               de1_q, de1_d;
    logic [NUM_WIN-1:0] hit1_q, hit1_d;
    logic               any1_q, any1_d;
    logic [1:0]         mode1_q, mode1_d;
    logic               ring1_q, ring1_d;

    // stage 2
    logic [DW-1:0]      rgb2_q, rgb2_d;
    logic               hs2_q, hs2_d;
    logic               vs2_q, vs2_d;
    logic               de2_q, de2_d;
    logic [NUM_WIN-1:0] hit2_q, hit2_d;

    // statistics
    logic [NUM_WIN-1:0][23:0] acc_q, acc_d;
    logic [NUM_WIN*24-1:0]    cnt_q, cnt_d;
    logic                     fdone_q, fdone_d;

    assign boundary = (i_vsync == VS_POL) && (vs_prev_q != VS_POL);
    // a request arriving in the boundary cycle itself commits immediately
    assign commit   = boundary && (pending_q || cfg_update);

    // Membership and ring detection; descending scan so the lowest index wins.
    always_comb begin
        hit      = '0;
        sel_any  = 1'b0;
        sel_mode = 2'b00;
        sel_ring = 1'b0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            hit[i] = en_s_q[i]
                  && (hl_s_q[i*CW +: CW] < hcount)
                  && (hcount < hr_s_q[i*CW +: CW])
                  && (vl_s_q[i*CW +: CW] < vcount)
                  && (vcount < vr_s_q[i*CW +: CW]);
            if (hit[i]) begin
                sel_any  = 1'b1;
                sel_mode = mode_s_q[2*i +: 2];
                sel_ring = (hcount == hl_s_q[i*CW +: CW] + ONE)
                        || (hcount == hr_s_q[i*CW +: CW] - ONE)
                        || (vcount == vl_s_q[i*CW +: CW] + ONE)
                        || (vcount == vr_s_q[i*CW +: CW] - ONE);
            end
        end
    end

    always_comb begin
        vs_prev_d = i_vsync;
        pending_d = pending_q;
        primed_d  = primed_q | boundary;
        en_s_d    = en_s_q;
        hl_s_d    = hl_s_q;
        hr_s_d    = hr_s_q;
        vl_s_d    = vl_s_q;
        vr_s_d    = vr_s_q;
        mode_s_d  = mode_s_q;

        if (boundary) begin
            pending_d = 1'b0;
        end else if (cfg_update) begin
            pending_d = 1'b1;
        end
        if (commit) begin
            en_s_d   = win_en;
            hl_s_d   = win_h_l;
            hr_s_d   = win_h_r;
            vl_s_d   = win_v_l;
            vr_s_d   = win_v_r;
            mode_s_d = win_mode;
        end

        // mode and ring are resolved in stage 0 so a commit
        // between stages cannot recolour an in-flight pixel
        rgb1_d  = i_rgb;
        hs1_d   = i_hsync;
        vs1_d   = i_vsync;
        de1_d   = i_de;
        hit1_d  = hit;
        any1_d  = sel_any;
        mode1_d = sel_mode;
        ring1_d = sel_ring;

        hs2_d  = hs1_q;
        vs2_d  = vs1_q;
        de2_d  = de1_q;
        hit2_d = hit1_q;
        if (!de1_q) begin
            rgb2_d = BLANK_RGB;
        end else if (!any1_q) begin
            rgb2_d = FILL_RGB;
        end else begin
            unique case (mode1_q)
                2'b00:   rgb2_d = rgb1_q;
                2'b01:   rgb2_d = ~rgb1_q;
                2'b10:   rgb2_d = ring1_q ? MARK_RGB : rgb1_q;
                default: rgb2_d = MARK_RGB;
            endcase
        end

        for (int i = 0; i < NUM_WIN; i++) begin
            acc_d[i] = acc_q[i];
            if (boundary) begin
                acc_d[i] = '0;
            end else if (de1_q && hit1_q[i] && (acc_q[i] != ACC_MAX)) begin
                acc_d[i] = acc_q[i] + 24'd1;
            end
        end
        cnt_d   = cnt_q;
        fdone_d = boundary && primed_q;
        if (boundary && primed_q) begin
            cnt_d = acc_q;
        end
    end

    always_ff @(posedge pixelclk or posedge reset) begin
        if (reset) begin
            vs_prev_q <= VS_POL;
            pending_q <= 1'b0;
            primed_q  <= 1'b0;
            en_s_q    <= '0;
            hl_s_q    <= '0;
            hr_s_q    <= '0;
            vl_s_q    <= '0;
            vr_s_q    <= '0;
            mode_s_q  <= '0;
            rgb1_q    <= '0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            de1_q     <= 1'b0;
            hit1_q    <= '0;
            any1_q    <= 1'b0;
            mode1_q   <= 2'b00;
            ring1_q   <= 1'b0;
            rgb2_q    <= '0;
            hs2_q     <= 1'b0;
            vs2_q     <= 1'b0;
            de2_q     <= 1'b0;
            hit2_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            fdone_q   <= 1'b0;
        end else begin
            vs_prev_q <= vs_prev_d;
            pending_q <= pending_d;
            primed_q  <= primed_d;
            en_s_q    <= en_s_d;
            hl_s_q    <= hl_s_d;
            hr_s_q    <= hr_s_d;
            vl_s_q    <= vl_s_d;
            vr_s_q    <= vr_s_d;
            mode_s_q  <= mode_s_d;
            rgb1_q    <= rgb1_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            de1_q     <= de1_d;
            hit1_q    <= hit1_d;
            any1_q    <= any1_d;
            mode1_q   <= mode1_d;
            ring1_q   <= ring1_d;
            rgb2_q    <= rgb2_d;
            hs2_q     <= hs2_d;
            vs2_q     <= vs2_d;
            de2_q     <= de2_d;
            hit2_q    <= hit2_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            fdone_q   <= fdone_d;
        end
    end

    assign cfg_busy   = pending_q;
    assign o_rgb      = rgb2_q;
    assign o_hsync    = hs2_q;
    assign o_vsync    = vs2_q;
    assign o_de       = de2_q;
    assign o_hit      = hit2_q;
    assign frame_done = fdone_q;
    assign win_count  = cnt_q;

endmodule
